// File: rtl/updown_counter_mod_pkg.sv
// Shared types for the up/down counter: count direction and boundary behaviour.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } bnd_mode_e;

endpackage

// File: rtl/updown_counter_mod_if.sv
// Control/status bundle of the up/down counter; master drives controls, slave is the counter.
interface updown_counter_mod_if #(
  parameter int unsigned WIDTH = 8
);

  logic             en;
  logic             mod;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  modport master (
    output en, mod, sat, load, load_val, limit, clr_ovf,
    input  count, tc, ovf
  );

  modport slave (
    input  en, mod, sat, load, load_val, limit, clr_ovf,
    output count, tc, ovf
  );

endinterface

// File: rtl/updown_counter_next.sv
// Combinational step of the counter: next value for one enabled step and whether a bound was hit.
module updown_counter_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] limit,
  input  dir_e             dir,
  input  bnd_mode_e        mode,
  output logic [WIDTH-1:0] next_count,
  output logic             at_bound
);

  // Bound checks precede the add/subtract, so the WIDTH-bit value never rolls over natively.
  always_comb begin
    next_count = count;
    at_bound   = 1'b0;
    if (dir == DIR_UP) begin
      if (count >= limit) begin
        at_bound   = 1'b1;
        next_count = (mode == MODE_SAT) ? limit : '0;
      end else begin
        next_count = count + WIDTH'(1);
      end
    end else begin
      if (count == '0) begin
        at_bound   = 1'b1;
        next_count = (mode == MODE_SAT) ? '0 : limit;
      end else if (count > limit) begin
        // Pull back into range after limit was lowered below the current count.
        next_count = limit;
      end else begin
        next_count = count - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down modulo counter with load, wrap/saturate, terminal-count pulse and sticky overflow.
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RST_VAL = 0
) (
  input logic                 clk,
  input logic                 rst,
  updown_counter_mod_if.slave bus
);

  localparam logic [WIDTH-1:0] RstCount = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] step_count;
  logic             step_bound;
  logic [WIDTH-1:0] load_clip;

  updown_counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .count      (count_q),
    .limit      (bus.limit),
    .dir        (dir_e'(bus.mod)),
    .mode       (bnd_mode_e'(bus.sat)),
    .next_count (step_count),
    .at_bound   (step_bound)
  );

  assign load_clip = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      count_d = load_clip;
    end else if (bus.en) begin
      count_d = step_count;
      tc_d    = step_bound;
    end
    // A fresh terminal count beats a simultaneous clear.
    ovf_d = tc_d | (ovf_q & ~bus.clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RstCount;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;

  a_ctrl_known: assert property (@(posedge clk) !rst |-> !$isunknown({bus.mod, bus.en, bus.load}));

  a_count_in_range: assert property (@(posedge clk)
    $past(!rst && (bus.load || bus.en)) |-> bus.count <= $past(bus.limit));

  a_tc_pulse: assert property (@(posedge clk)
    (bus.tc && $past(bus.tc)) |-> $past(bus.en && !bus.load && !rst));

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed checks of the 3-bit up/down counter plus a randomised run against a rule-level model.
module tb_updown_counter_mod;

  localparam int unsigned W = 3;

  logic clk_tb = 1'b0;
  logic rst    = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_tb = ~clk_tb;

  updown_counter_mod_if #(.WIDTH(W)) bus ();

  updown_counter_mod #(
    .WIDTH   (W),
    .RST_VAL (0)
  ) dut (
    .clk (clk_tb),
    .rst (rst),
    .bus (bus.slave)
  );

  // Model state: plain integers, updated from the inputs sampled at each rising edge.
  int m_count = 0;
  int m_tc    = 0;
  int m_ovf   = 0;
  bit m_valid = 1'b0;

  always @(posedge clk_tb) begin
    int c, t, o, lim;
    c   = m_count;
    o   = m_ovf;
    lim = int'(bus.limit);
    t   = 0;
    if (rst) begin
      c = 0;
      o = 0;
    end else begin
      if (bus.load) begin
        c = (int'(bus.load_val) < lim) ? int'(bus.load_val) : lim;
      end else if (bus.en && bus.mod) begin
        if (c < lim) c = c + 1;
        else begin t = 1; c = bus.sat ? lim : 0; end
      end else if (bus.en) begin
        if (c == 0) begin t = 1; c = bus.sat ? 0 : lim; end
        else if (c > lim) c = lim;
        else c = c - 1;
      end
      if (t == 1) o = 1;
      else if (bus.clr_ovf) o = 0;
    end
    m_count <= c;
    m_tc    <= t;
    m_ovf   <= o;
    if (rst) m_valid <= 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_tb) begin
    if (m_valid) begin
      check("model count", int'(bus.count), m_count);
      check("model tc", int'(bus.tc), m_tc);
      check("model ovf", int'(bus.ovf), m_ovf);
    end
  end

  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic load_to(input int v, input int lim);
    bus.load     = 1'b1;
    bus.load_val = W'(v);
    bus.limit    = W'(lim);
    tick();
    bus.load = 1'b0;
  endtask

  initial begin
    int exp1 [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    int exp2 [8]  = '{1, 2, 3, 4, 5, 5, 5, 5};
    bus.en = 1'b0; bus.mod = 1'b1; bus.sat = 1'b0; bus.load = 1'b0;
    bus.load_val = '0; bus.limit = 3'd7; bus.clr_ovf = 1'b0;

    // 1: reset, then full-range wrap count
    tick(); tick();
    check("reset count", int'(bus.count), 0);
    check("reset tc", int'(bus.tc), 0);
    check("reset ovf", int'(bus.ovf), 0);
    rst = 1'b0; bus.en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t1 count", int'(bus.count), exp1[i]);
      check("t1 tc", int'(bus.tc), (i == 7) ? 1 : 0);
    end
    check("t1 ovf", int'(bus.ovf), 1);

    // 2: saturate up at 5, then step down
    bus.en = 1'b0; load_to(0, 5);
    bus.en = 1'b1; bus.sat = 1'b1; bus.mod = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2 count", int'(bus.count), exp2[i]);
      check("t2 tc", int'(bus.tc), (i >= 5) ? 1 : 0);
    end
    bus.mod = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2 down count", int'(bus.count), 4 - i);
    end

    // 3: wrap down from 0, then clear ovf
    bus.en = 1'b0; load_to(0, 5);
    bus.en = 1'b1; bus.sat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3 count", int'(bus.count), 5 - i);
      check("t3 tc", int'(bus.tc), (i == 0) ? 1 : 0);
    end
    bus.en = 1'b0; bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("t3 ovf cleared", int'(bus.ovf), 0);

    // 4: load clipped to limit, load beats en, range recovery on limit drop
    load_to(6, 4);
    check("t4 load clip", int'(bus.count), 4);
    bus.en = 1'b1; bus.mod = 1'b1; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    check("t4 load wins", int'(bus.count), 4);
    check("t4 load tc", int'(bus.tc), 0);
    bus.limit = 3'd2; bus.mod = 1'b0;
    tick();
    check("t4 recover count", int'(bus.count), 2);
    check("t4 recover tc", int'(bus.tc), 0);

    // 5: reset overrides load and en with ovf set
    bus.en = 1'b0; load_to(3, 3);
    bus.en = 1'b1; bus.mod = 1'b1;
    tick();
    check("t5 pre ovf", int'(bus.ovf), 1);
    bus.en = 1'b0; load_to(3, 3);
    rst = 1'b1; bus.en = 1'b1; bus.load = 1'b1;
    tick();
    rst = 1'b0; bus.load = 1'b0; bus.en = 1'b0;
    check("t5 rst count", int'(bus.count), 0);
    check("t5 rst tc", int'(bus.tc), 0);
    check("t5 rst ovf", int'(bus.ovf), 0);

    // 6: random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst          = ($urandom_range(63) == 0);
      bus.load     = ($urandom_range(7) == 0);
      bus.en       = ($urandom_range(3) != 0);
      bus.mod      = 1'($urandom_range(1));
      bus.sat      = 1'($urandom_range(1));
      bus.clr_ovf  = ($urandom_range(15) == 0);
      bus.load_val = W'($urandom_range(7));
      if ($urandom_range(15) == 0) bus.limit = W'($urandom_range(7));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
